dcache_refill: RTL and testbench

- Miss-side refill engine for the data cache.
- On a cache miss it fetches one aligned line of 2**BURST_SCALE 32-bit words from the DRAM controller.
- It writes each word into the cache's load port (load_oe/load_addr/load_wdata/load_we) as a full-word store, then pulses done.
- It sits between the pipeline's miss detection, the DRAM read channel and the cache's second RAM port, and never drives a load write in a cycle where the processor writes the cache.

---
 rtl/dcache_refill.sv | 121 ++++++++++++
 tb/tb_dcache_refill.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill.sv
// Data-cache miss refill engine: fetches one aligned line from DRAM and replays it into the cache load port.
// Optional critical-word-first ordering is enabled by defining DCACHE_REFILL_CRITICAL_FIRST_EN.
module dcache_refill #(
    parameter int MEM_SCALE   = 27,
    parameter int BURST_SCALE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req,
    input  logic [MEM_SCALE-1:0] miss_addr,
    output logic                 busy,
    output logic                 done,
    input  logic [3:0]           cpu_we,
    output logic                 dram_req,
    output logic [MEM_SCALE-1:0] dram_addr,
    input  logic                 dram_ack,
    input  logic                 dram_rvalid,
    input  logic [31:0]          dram_rdata,
    output logic                 dram_rready,
    output logic                 load_oe,
    output logic [MEM_SCALE-1:0] load_addr,
    output logic [31:0]          load_wdata,
    output logic [3:0]           load_we,
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
    output logic                 crit_valid,
`endif
    output logic [1:0]           dbg_state
);
    localparam int LINE_LSB = BURST_SCALE + 2;
    localparam logic [BURST_SCALE:0] LAST_BEAT = (BURST_SCALE+1)'((1 << BURST_SCALE) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [MEM_SCALE-1:LINE_LSB]     base_q;
    logic [BURST_SCALE:0]            cnt_q;
    logic                            hold_valid;
    logic [31:0]                     hold_data;
    logic [BURST_SCALE-1:0]          word_idx;
    logic [MEM_SCALE-1:0]            req_addr;
    logic                            write;

    // DRAM read channel: a beat transfers on a cycle where dram_rvalid and dram_rready are both high;
    // the hold register is the single slot between the channel and the cache load port.
    assign write = hold_valid & ~cpu_we[0];

`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
    logic [BURST_SCALE-1:0] first_idx;
    logic                   unused_bits;
    assign unused_bits = ^{cpu_we[3:1], miss_addr[1:0]};
    assign word_idx    = first_idx + cnt_q[BURST_SCALE-1:0];
    assign req_addr    = {base_q, first_idx, 2'b00};
    assign crit_valid  = write & (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_idx <= '0;
        end else if (state_q == IDLE && miss_req) begin
            first_idx <= miss_addr[LINE_LSB-1:2];
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{cpu_we[3:1], miss_addr[LINE_LSB-1:0]};
    assign word_idx    = cnt_q[BURST_SCALE-1:0];
    assign req_addr    = {base_q, {LINE_LSB{1'b0}}};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && miss_req) begin
                base_q <= miss_addr[MEM_SCALE-1:LINE_LSB];
            end
            if (state_q == REQ && dram_ack) begin
                cnt_q <= '0;
            end
            if (dram_rvalid && dram_rready) begin
                hold_valid <= 1'b1;
                hold_data  <= dram_rdata;
            end else if (write) begin
                hold_valid <= 1'b0;
                cnt_q      <= cnt_q + (BURST_SCALE+1)'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_req) state_d = REQ;
            REQ:     if (dram_ack) state_d = DATA;
            DATA:    if (write && cnt_q == LAST_BEAT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign dram_req    = (state_q == REQ);
    assign dram_addr   = dram_req ? req_addr : '0;
    assign dram_rready = (state_q == DATA) & ~hold_valid;
    // The load port is gated combinationally by cpu_we so a processor write always wins the RAM port.
    assign load_oe     = write;
    assign load_we     = {4{write}};
    assign load_addr   = hold_valid ? {base_q, word_idx, 2'b00} : '0;
    assign load_wdata  = hold_valid ? hold_data : '0;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_dcache_refill.sv
// Self-checking bench for dcache_refill: table-driven refills plus randomized ones against a line-order model.
module tb_dcache_refill;
    localparam int MEM_SCALE   = 27;
    localparam int BURST_SCALE = 2;
    localparam int N           = 1 << BURST_SCALE;
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 miss_req;
    logic [MEM_SCALE-1:0] miss_addr;
    logic                 busy, done;
    logic [3:0]           cpu_we;
    logic                 dram_req;
    logic [MEM_SCALE-1:0] dram_addr;
    logic                 dram_ack, dram_rvalid;
    logic [31:0]          dram_rdata;
    logic                 dram_rready;
    logic                 load_oe;
    logic [MEM_SCALE-1:0] load_addr;
    logic [31:0]          load_wdata;
    logic [3:0]           load_we;
    logic [1:0]           dbg_state;
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
    logic                 crit_valid;
`endif

    dcache_refill #(.MEM_SCALE(MEM_SCALE), .BURST_SCALE(BURST_SCALE)) dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .done(done), .cpu_we(cpu_we),
        .dram_req(dram_req), .dram_addr(dram_addr), .dram_ack(dram_ack),
        .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata), .dram_rready(dram_rready),
        .load_oe(load_oe), .load_addr(load_addr), .load_wdata(load_wdata), .load_we(load_we),
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
        .crit_valid(crit_valid),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int coll_left = 0;
    bit rnd_g = 1'b0;

    logic [MEM_SCALE-1:0] exp_addr_q[$];
    logic [31:0]          exp_data_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [MEM_SCALE-1:0] model_word_addr(input logic [MEM_SCALE-1:0] a, input int k);
        longint line_bytes = 4 * N;
        longint al    = longint'(a);
        longint base  = al - (al % line_bytes);
        longint first = CRIT ? (al % line_bytes) / 4 : 0;
        return MEM_SCALE'(base + 4 * ((first + k) % N));
    endfunction

    function automatic logic [MEM_SCALE-1:0] model_req_addr(input logic [MEM_SCALE-1:0] a);
        longint al = longint'(a);
        return MEM_SCALE'(CRIT ? al - (al % 4) : al - (al % (4 * N)));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cpu_we = {3'($urandom_range(0, 7)), 1'((coll_left > 0) || (rnd_g && $urandom_range(0, 2) == 0))};
        if (coll_left > 0) coll_left--;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dram_req"}, dram_req, 0);
        chk({tag, "_dram_addr"}, dram_addr, 0);
        chk({tag, "_rready"}, dram_rready, 0);
        chk({tag, "_load_oe"}, load_oe, 0);
        chk({tag, "_load_we"}, load_we, 0);
        chk({tag, "_load_addr"}, load_addr, 0);
        chk({tag, "_load_wdata"}, load_wdata, 0);
        chk({tag, "_state"}, dbg_state, 0);
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
        chk({tag, "_crit_valid"}, crit_valid, 0);
`endif
    endtask

    typedef struct {
        logic [MEM_SCALE-1:0] addr;
        int                   ack_dly;
        int                   gap;
        int                   coll_beat;
        int                   coll_len;
        bit                   rnd_cpu;
        bit                   extra_miss;
        int                   abort_after;
        logic [MEM_SCALE-1:0] exp_req_addr;
    } vec_t;

    task automatic run_refill(input vec_t v);
        logic [31:0] d;
        bit ok;
        bit first = 1'b1;
        rnd_g = v.rnd_cpu;
        coll_left = 0;
        step();
        miss_req = 1'b1;
        miss_addr = v.addr;
        @(negedge clk);
        step();
        miss_req = 1'b0;
        @(negedge clk);
        chk("busy_after_miss", busy, 1);
        chk("dram_req_on", dram_req, 1);
        chk("dram_addr_table", dram_addr, v.exp_req_addr);
        chk("dram_addr_model", dram_addr, model_req_addr(v.addr));
        for (int i = 0; i < v.ack_dly; i++) begin
            step();
            dram_rvalid = 1'b1;
            dram_rdata  = $urandom;
            @(negedge clk);
            chk("dram_req_hold", dram_req, 1);
            chk("rready_outside_data", dram_rready, 0);
        end
        step();
        dram_rvalid = 1'b0;
        dram_ack = 1'b1;
        @(negedge clk);
        step();
        dram_ack = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < v.gap; g++) begin
                dram_rvalid = 1'b0;
                @(negedge clk);
                if (first) begin
                    chk("dram_req_drop", dram_req, 0);
                    first = 1'b0;
                end
                step();
            end
            d = $urandom;
            dram_rvalid = 1'b1;
            dram_rdata  = d;
            if (v.extra_miss && k == 1) begin
                miss_req  = 1'b1;
                miss_addr = 27'h40;
            end
            ok = 1'b0;
            for (int w = 0; w < 20 && !ok; w++) begin
                @(negedge clk);
                if (first) begin
                    chk("dram_req_drop", dram_req, 0);
                    first = 1'b0;
                end
                if (dram_rready) begin
                    ok = 1'b1;
                    exp_addr_q.push_back(model_word_addr(v.addr, k));
                    exp_data_q.push_back(d);
                    if (k == v.coll_beat) coll_left = v.coll_len;
                end
                step();
            end
            dram_rvalid = 1'b0;
            dram_rdata  = $urandom;
            chk("beat_accepted", ok, 1);
            if (!ok) return;
            if (v.abort_after > 0 && k == v.abort_after - 1) begin
                @(negedge clk);
                #2 rst = 1'b0;
                #1 check_all_zero("abort");
                step();
                step();
                rst = 1'b1;
                step();
                return;
            end
        end
        ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
            else step();
        end
        chk("done_seen", ok, 1);
        step();
        miss_req = 1'b0;
        @(negedge clk);
        chk("idle_dram_req", dram_req, 0);
        chk("idle_busy", busy, 0);
        coll_left = 0;
        rnd_g = 1'b0;
        step();
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin
        bit pend = 1'b0;
        bit done_due = 1'b0;
        bit after_done = 1'b0;
        bit wr_exp;
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
                done_due = 1'b0;
                after_done = 1'b0;
                wcnt = 0;
                exp_addr_q.delete();
                exp_data_q.delete();
            end else begin
                wr_exp = pend && !cpu_we[0];
                chk("conflict_invariant", load_we[0] & cpu_we[0], 0);
                chk("oe_eq_we0", load_oe, load_we[0]);
                chk("load_we", load_we, wr_exp ? 4'hF : 4'h0);
                if (pend) chk("rready_while_held", dram_rready, 0);
                chk("done", done, done_due);
                if (done_due) chk("busy_in_done", busy, 1);
                if (after_done) chk("busy_after_done", busy, 0);
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
                chk("crit_valid", crit_valid, wr_exp && wcnt == 0);
`endif
                after_done = done_due;
                done_due = 1'b0;
                if (wr_exp) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL write_unexpected: got addr 0x%0h with no expected write", load_addr);
                    end else begin
                        chk("load_addr", load_addr, exp_addr_q.pop_front());
                        chk("load_wdata", load_wdata, exp_data_q.pop_front());
                    end
                    pend = 1'b0;
                    wcnt++;
                    if (wcnt == N) begin
                        done_due = 1'b1;
                        wcnt = 0;
                    end
                end
                if (dram_rvalid && dram_rready) pend = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[8];
        vec_t rv;
        vecs[0] = '{27'h1238,    3, 0, -1, 0, 1'b0, 1'b0, 0, CRIT ? 27'h1238 : 27'h1230};
        vecs[1] = '{27'h1230,    1, 0,  1, 2, 1'b0, 1'b0, 0, 27'h1230};
        vecs[2] = '{27'h1234,    0, 1, -1, 0, 1'b0, 1'b0, 0, CRIT ? 27'h1234 : 27'h1230};
        vecs[3] = '{27'h1230,    2, 0, -1, 0, 1'b0, 1'b1, 0, 27'h1230};
        vecs[4] = '{27'h40,      0, 0, -1, 0, 1'b0, 1'b0, 0, 27'h40};
        vecs[5] = '{27'h7FFFFFE, 1, 2,  0, 3, 1'b0, 1'b0, 0, CRIT ? 27'h7FFFFFC : 27'h7FFFFF0};
        vecs[6] = '{27'h2004,    0, 0, -1, 0, 1'b0, 1'b0, 2, CRIT ? 27'h2004 : 27'h2000};
        vecs[7] = '{27'h1238,    0, 0, -1, 0, 1'b0, 1'b0, 0, CRIT ? 27'h1238 : 27'h1230};

        rst = 1'b0;
        miss_req = 1'b0;
        miss_addr = '0;
        cpu_we = '0;
        dram_ack = 1'b0;
        dram_rvalid = 1'b0;
        dram_rdata = '0;
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_refill(vecs[i]);

        for (int i = 0; i < 10; i++) begin
            rv.addr         = MEM_SCALE'($urandom);
            rv.ack_dly      = $urandom_range(0, 4);
            rv.gap          = $urandom_range(0, 2);
            rv.coll_beat    = -1;
            rv.coll_len     = 0;
            rv.rnd_cpu      = 1'b1;
            rv.extra_miss   = 1'b0;
            rv.abort_after  = 0;
            rv.exp_req_addr = model_req_addr(rv.addr);
            run_refill(rv);
        end

        repeat (3) step();
        chk("final_queue_empty", exp_addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
